serial_adder_sched: RTL
=======================

# serial_adder_sched

Round-robin scheduler that shares one serial adder among `N_REQ` parallel requesters. It accepts operand pairs over per-requester valid/ready handshakes and serialises the winner's operands onto the adder's `en_i`/`ina`/`inb` lines. It then deserialises the adder's `en_o`/`out` result and returns the sum, tagged with the requester ID, on a single response channel. It sits between the client logic and the serial adder, which is otherwise unchanged.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `OP_W`, 2: operand width in bits; the sum is `OP_W+1` bits.
- `TIMEOUT`, 16: maximum cycles to wait for `add_en_o` after the last operand bit.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  N_REQ*OP_W  operand A of each requester; requester i occupies slice [i*OP_W +: OP_W].
- `req_b`  in  N_REQ*OP_W  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(N_REQ)  ID of the requester that owns the response.
- `rsp_sum`  out  OP_W+1  sum, LSB at bit 0.
- `rsp_err`  out  1  adder timed out or broke protocol; `rsp_sum` is 0.
- `add_en_i`  out  1  operand-bit valid to the adder.
- `add_ina`, `add_inb`  out  1 each  serial operand bits, LSB first.
- `add_en_o`  in  1  result-bit valid from the adder.
- `add_out`  in  1  serial result bit, LSB first.

## Operation
- **States:** IDLE, SEND, WAIT, RECV, RESP.
- **IDLE:**
  - The round-robin arbiter picks the first requester with `req_valid` set, searching upward from pointer `ptr` and wrapping at `N_REQ`.
  - `req_ready[g]` is asserted combinationally for the winner `g`, only while in IDLE.
  - On the handshake: latch A, B and ID; set `ptr` to `g+1` (mod `N_REQ`); clear `bit_cnt`; go to SEND.
  - With no valid request, stay in IDLE; `ptr` does not change.
- **SEND:** for `OP_W` cycles, drive `add_en_i=1`, `add_ina=A[bit_cnt]`, `add_inb=B[bit_cnt]`. After the last bit, go to WAIT and clear `tmo_cnt`.
- **WAIT:**
  - `add_en_o=1`: capture `add_out` into `sum[0]` and go to RECV with `bit_cnt=1`.
  - Otherwise increment `tmo_cnt`. When it reaches `TIMEOUT`, go to RESP with `rsp_err=1` and `sum=0`.
- **RECV:**
  - Each cycle with `add_en_o=1`: capture into `sum[bit_cnt]`. After bit `OP_W`, go to RESP with `err=0`.
  - If `add_en_o=0` before all `OP_W+1` bits are received: go to RESP with `err=1` and `sum=0`.
- **RESP:**
  - `rsp_valid=1`; `rsp_id`, `rsp_sum` and `rsp_err` are held stable.
  - On `rsp_valid && rsp_ready`, return to IDLE.
  - No new request is accepted until then: exactly one transaction is in flight.
- **Ignored inputs:** `add_en_o` is ignored in IDLE, SEND and RESP.
- **Reset (`rst_n`=0, at any time including mid-transaction):** state=IDLE, `ptr=0`, all counters 0. Outputs `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_err=0`, `add_en_i=0`, `add_ina=0`, `add_inb=0`. The in-flight transaction is dropped with no response.
- **Idle adder lines:** outside SEND, `add_en_i`, `add_ina` and `add_inb` are 0.

## Timing
- **Accept:** cycle 0, the edge on which `req_valid[g] && req_ready[g]` is sampled.
- **Operand bits:** `add_en_i` is high in cycles 1..`OP_W`; all adder-side outputs are registered.
- **Result:** if `add_en_o` first rises in cycle k, `rsp_valid` rises in cycle k+`OP_W`+1.
- **Timeout:** `rsp_valid` rises `TIMEOUT`+1 cycles after the last SEND cycle.
- **Back-to-back:** with `rsp_ready` held high, a new grant can occur in the cycle after the response handshake.
- **Fairness:** with all requesters continuously valid, the grant order is 0,1,…,`N_REQ`−1,0,…

## Structure
- **Package `serial_adder_sched_pkg`:**
  - `state_t` enum with the five states.
  - Defaults for `N_REQ`, `OP_W` and `TIMEOUT`.
  - `SUM_W = OP_W+1`.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and `gnt_id`.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- **Single request, `OP_W`=2:** requester 2 sends a=3, b=2; adder model raises `en_o` 2 cycles after the last `en_i` with bits 1,0,1 → `rsp_valid` with id=2, sum=5, err=0, exactly 3 cycles after `en_o` rises; `add_ina` sequence 1,1 and `add_inb` sequence 0,1.
- **All valid, round robin:** all four requesters continuously valid with distinct operands, `rsp_ready`=1 → grant/response IDs 0,1,2,3,0 and each sum correct.
- **Response back-pressure:** `rsp_ready`=0 for 5 cycles → `rsp_valid`, id and sum held stable; no `req_ready` pulse until the handshake.
- **Timeout:** adder model never raises `en_o` → response with err=1, sum=0 after 16+1 wait cycles; the next request is then served normally.
- **Broken burst:** `en_o` high for 1 cycle only → err=1, sum=0.
- **Reset mid-transfer:** assert `rst_n`=0 during SEND, release → all outputs 0 and no response; first grant goes to requester 0.

Source files
------------

// File: rtl/serial_adder_sched_pkg.sv
// Shared types and default parameters for the serial adder scheduler.
package serial_adder_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        RESP
    } state_t;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_OP_W    = 2;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned SUM_W       = DEF_OP_W + 1;

    function automatic int unsigned sum_w(input int unsigned op_w);
        return op_w + 1;
    endfunction

endpackage

// File: rtl/serial_adder_sched_if.sv
// Requester, response and serial-adder signal bundle; slave is the scheduler side.
interface serial_adder_sched_if
    import serial_adder_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned OP_W  = DEF_OP_W
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [OP_W:0]         rsp_sum;
    logic                  rsp_err;

    logic                  add_en_i;
    logic                  add_ina;
    logic                  add_inb;
    logic                  add_en_o;
    logic                  add_out;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_en_o, add_out,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err,
               add_en_i, add_ina, add_inb
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_en_o, add_out,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err,
               add_en_i, add_ina, add_inb
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping at N.
module rr_arbiter
    import serial_adder_sched_pkg::*;
#(
    parameter int unsigned N = DEF_N_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int unsigned ID_W = $clog2(N);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = i + 32'(ptr);
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_adder_sched.sv
// Shares one serial adder among N_REQ requesters: arbitrate, serialise operands,
// deserialise the result and return it tagged with the requester ID.
module serial_adder_sched
    import serial_adder_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_sched_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned RES_W = sum_w(OP_W);
    localparam int unsigned CNT_W = $clog2(OP_W + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RES_W-1:0]   sum_q, sum_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_err_q, rsp_err_d;
    logic               add_en_i_q, add_en_i_d;
    logic               add_ina_q, add_ina_d;
    logic               add_inb_q, add_inb_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               arb_en;

    // Gated by rst_n so req_ready stays low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        sum_d       = sum_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        add_en_i_d  = 1'b0;
        add_ina_d   = 1'b0;
        add_inb_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    a_d        = bus.req_a[32'(gnt_id) * OP_W +: OP_W];
                    b_d        = bus.req_b[32'(gnt_id) * OP_W +: OP_W];
                    id_d       = gnt_id;
                    ptr_d      = (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
                    bit_cnt_d  = '0;
                    add_en_i_d = 1'b1;
                    add_ina_d  = a_d[0];
                    add_inb_d  = b_d[0];
                    state_d    = SEND;
                end
            end

            // Adder lines are registered one bit ahead: bit_cnt_q is the bit on the wire now.
            SEND: begin
                if (bit_cnt_q == CNT_W'(OP_W - 1)) begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end else begin
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    add_en_i_d = 1'b1;
                    add_ina_d  = a_q[bit_cnt_d];
                    add_inb_d  = b_q[bit_cnt_d];
                end
            end

            WAIT: begin
                if (bus.add_en_o) begin
                    sum_d     = '0;
                    sum_d[0]  = bus.add_out;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = RECV;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            RECV: begin
                if (bus.add_en_o) begin
                    sum_d[bit_cnt_q] = bus.add_out;
                    if (bit_cnt_q == CNT_W'(OP_W)) begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = id_q;
                        rsp_sum_d   = sum_d;
                        rsp_err_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            add_en_i_q  <= 1'b0;
            add_ina_q   <= 1'b0;
            add_inb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            sum_q       <= sum_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
            add_en_i_q  <= add_en_i_d;
            add_ina_q   <= add_ina_d;
            add_inb_q   <= add_inb_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.add_en_i  = add_en_i_q;
    assign bus.add_ina   = add_ina_q;
    assign bus.add_inb   = add_inb_q;

endmodule
